issue_queue: RTL and testbench

Out-of-order issue queue directly downstream of the rename/map stage. It accepts renamed uops (physical rd/rs1/rs2 tags) and tracks source-operand readiness through an internal physical-register ready table and a writeback wakeup bus. Each cycle it issues the oldest fully-ready uop to the execute stage over a valid/ready handshake, and it raises `full` back to the front end.

---
 rtl/issue_queue.sv | 166 ++++++++++++++++
 tb/tb_issue_queue.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/issue_queue.sv
// rtl/issue_queue.sv - out-of-order issue queue with ready table and wakeup
package issue_queue_pkg;
    localparam int PHY_RF_DEPTH      = 128;
    localparam int PHY_RF_ADDR_WIDTH = $clog2(PHY_RF_DEPTH);

    typedef logic [PHY_RF_ADDR_WIDTH-1:0] tag_t;

    typedef struct packed {
        logic [7:0] op;
        logic       rd_valid;
        tag_t       rd;
        logic       rs1_valid;
        tag_t       rs1;
        logic       rs2_valid;
        tag_t       rs2;
    } uop_t;
endpackage

module issue_queue
    import issue_queue_pkg::*;
#(
    parameter int IQ_DEPTH     = 8,
    parameter int PHY_RF_DEPTH = issue_queue_pkg::PHY_RF_DEPTH
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            flush,
    input  uop_t                            uop_in,
    input  logic                            uop_in_valid,
    output logic                            full,
    input  logic                            wakeup_valid,
    input  logic [$clog2(PHY_RF_DEPTH)-1:0] wakeup_tag,
    output uop_t                            uop_out,
    output logic                            uop_out_valid,
    input  logic                            issue_ready,
    output logic [$clog2(IQ_DEPTH):0]       count
);
    localparam int IW = $clog2(IQ_DEPTH);
    localparam int CW = IW + 1;

    typedef struct packed {
        logic valid;
        uop_t uop;
        logic rs1_rdy;
        logic rs2_rdy;
    } entry_t;

    entry_t                  ent   [IQ_DEPTH];
    entry_t                  ent_n [IQ_DEPTH];
    logic [PHY_RF_DEPTH-1:0] ready_table;
    logic [PHY_RF_DEPTH-1:0] ready_table_n;

    logic          sel_found;
    logic [IW-1:0] sel_idx;
    logic          load_en;
    logic          issue;
    logic          dispatch;
    logic [CW-1:0] wr_idx;
    entry_t        new_ent;

    assign full     = (count == CW'(IQ_DEPTH));
    assign load_en  = !uop_out_valid || issue_ready;
    assign issue    = load_en && sel_found;
    assign dispatch = uop_in_valid && !full && !flush;
    assign wr_idx   = count - CW'(issue);

    // Oldest ready entry: scan from the top so the lowest index wins
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int i = IQ_DEPTH - 1; i >= 0; i--) begin
            if (ent[i].valid && ent[i].rs1_rdy && ent[i].rs2_rdy) begin
                sel_found = 1'b1;
                sel_idx   = IW'(i);
            end
        end
    end

    // Incoming entry, with same-cycle wakeup bypass onto its sources
    always_comb begin
        new_ent         = '0;
        new_ent.valid   = 1'b1;
        new_ent.uop     = uop_in;
        new_ent.rs1_rdy = !uop_in.rs1_valid || ready_table[uop_in.rs1]
                          || (wakeup_valid && wakeup_tag == uop_in.rs1);
        new_ent.rs2_rdy = !uop_in.rs2_valid || ready_table[uop_in.rs2]
                          || (wakeup_valid && wakeup_tag == uop_in.rs2);
    end

    // Next entry state: collapse over the issued slot, apply wakeup, append dispatch
    always_comb begin
        for (int i = 0; i < IQ_DEPTH; i++) begin
            ent_n[i] = ent[i];
        end
        if (issue) begin
            for (int i = 0; i < IQ_DEPTH - 1; i++) begin
                if (IW'(i) >= sel_idx) begin
                    ent_n[i] = ent[i+1];
                end
            end
            ent_n[IQ_DEPTH-1] = '0;
        end
        if (wakeup_valid) begin
            for (int i = 0; i < IQ_DEPTH; i++) begin
                if (ent_n[i].valid && ent_n[i].uop.rs1_valid && ent_n[i].uop.rs1 == wakeup_tag) begin
                    ent_n[i].rs1_rdy = 1'b1;
                end
                if (ent_n[i].valid && ent_n[i].uop.rs2_valid && ent_n[i].uop.rs2 == wakeup_tag) begin
                    ent_n[i].rs2_rdy = 1'b1;
                end
            end
        end
        if (dispatch) begin
            for (int i = 0; i < IQ_DEPTH; i++) begin
                if (CW'(i) == wr_idx) begin
                    ent_n[i] = new_ent;
                end
            end
        end
    end

    // Ready table: wakeup sets, a dispatched destination clears (clear wins)
    always_comb begin
        ready_table_n = ready_table;
        if (wakeup_valid) begin
            ready_table_n[wakeup_tag] = 1'b1;
        end
        if (dispatch && uop_in.rd_valid) begin
            ready_table_n[uop_in.rd] = 1'b0;
        end
    end

    // Queue entries, occupancy and ready table
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            for (int i = 0; i < IQ_DEPTH; i++) begin
                ent[i] <= '0;
            end
            count       <= '0;
            ready_table <= '1;
        end else begin
            for (int i = 0; i < IQ_DEPTH; i++) begin
                ent[i] <= ent_n[i];
            end
            count       <= count + CW'(dispatch) - CW'(issue);
            ready_table <= ready_table_n;
        end
    end

    // Output register: loads when empty or being consumed, holds on stall
    always_ff @(posedge clk) begin
        if (rst) begin
            uop_out       <= '0;
            uop_out_valid <= 1'b0;
        end else if (flush) begin
            uop_out_valid <= 1'b0;
        end else if (load_en) begin
            if (sel_found) begin
                uop_out       <= ent[sel_idx].uop;
                uop_out_valid <= 1'b1;
            end else begin
                uop_out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_issue_queue.sv
// tb/tb_issue_queue.sv - directed table-driven bench for issue_queue
module tb_issue_queue;
    import issue_queue_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       flush;
    uop_t       uop_in;
    logic       uop_in_valid;
    logic       full;
    logic       wakeup_valid;
    logic [6:0] wakeup_tag;
    uop_t       uop_out;
    logic       uop_out_valid;
    logic       issue_ready;
    logic [3:0] count;

    int passed = 0;
    int total  = 0;

    issue_queue #(.IQ_DEPTH(8), .PHY_RF_DEPTH(128)) dut (
        .clk           (clk),
        .rst           (rst),
        .flush         (flush),
        .uop_in        (uop_in),
        .uop_in_valid  (uop_in_valid),
        .full          (full),
        .wakeup_valid  (wakeup_valid),
        .wakeup_tag    (wakeup_tag),
        .uop_out       (uop_out),
        .uop_out_valid (uop_out_valid),
        .issue_ready   (issue_ready),
        .count         (count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       flush;
        logic       v;
        uop_t       u;
        logic       wv;
        logic [6:0] wt;
        logic       ir;
        int         e_cnt;
        logic       e_full;
        logic       e_ov;
        int         e_op;
    } vec_t;

    vec_t tv[$];

    function automatic uop_t mk(int op, bit rdv, int rd, bit r1v, int r1, bit r2v, int r2);
        uop_t u;
        u.op        = 8'(op);
        u.rd_valid  = rdv;
        u.rd        = 7'(rd);
        u.rs1_valid = r1v;
        u.rs1       = 7'(r1);
        u.rs2_valid = r2v;
        u.rs2       = 7'(r2);
        return u;
    endfunction

    function automatic vec_t vec(bit r, bit f, bit v, uop_t u, bit wv, int wt, bit ir,
                                 int ec, bit ef, bit eov, int eop);
        vec_t t;
        t.rst = r; t.flush = f; t.v = v; t.u = u; t.wv = wv; t.wt = 7'(wt); t.ir = ir;
        t.e_cnt = ec; t.e_full = ef; t.e_ov = eov; t.e_op = eop;
        return t;
    endfunction

    task automatic chk(string name, int act, int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic expect_state(string name, int ec, bit ef, bit eov, int eop);
        chk({name, " count"}, int'(count), ec);
        chk({name, " full"}, int'(full), int'(ef));
        chk({name, " out_valid"}, int'(uop_out_valid), int'(eov));
        if (eov) chk({name, " out_op"}, int'(uop_out.op), eop);
    endtask

    task automatic drive(bit r, bit f, bit v, uop_t u, bit wv, int wt, bit ir);
        rst = r; flush = f; uop_in_valid = v; uop_in = u;
        wakeup_valid = wv; wakeup_tag = 7'(wt); issue_ready = ir;
        @(posedge clk);
        #1;
    endtask

    uop_t z;

    initial begin
        z = '0;
        rst = 1'b1; flush = 1'b0; uop_in = '0; uop_in_valid = 1'b0;
        wakeup_valid = 1'b0; wakeup_tag = '0; issue_ready = 1'b1;

        // reset and first dispatch
        tv.push_back(vec(1, 0, 0, z, 0, 0, 1, 0, 0, 0, 0));
        tv.push_back(vec(1, 0, 0, z, 0, 0, 1, 0, 0, 0, 0));
        tv.push_back(vec(0, 0, 0, z, 0, 0, 1, 0, 0, 0, 0));
        tv.push_back(vec(0, 0, 1, mk(1, 1, 5, 1, 1, 1, 2), 0, 0, 1, 1, 0, 0, 0));
        tv.push_back(vec(0, 0, 0, z, 0, 0, 1, 0, 0, 1, 1));
        tv.push_back(vec(0, 0, 0, z, 0, 0, 1, 0, 0, 0, 0));
        // dependency wakeup: A rd=p7, B waits on p7
        tv.push_back(vec(0, 0, 1, mk(2, 1, 7, 1, 1, 0, 0), 0, 0, 1, 1, 0, 0, 0));
        tv.push_back(vec(0, 0, 1, mk(3, 0, 0, 1, 7, 0, 0), 0, 0, 1, 1, 0, 1, 2));
        tv.push_back(vec(0, 0, 0, z, 0, 0, 1, 1, 0, 0, 0));
        tv.push_back(vec(0, 0, 0, z, 0, 0, 1, 1, 0, 0, 0));
        tv.push_back(vec(0, 0, 0, z, 1, 7, 1, 1, 0, 0, 0));
        tv.push_back(vec(0, 0, 0, z, 0, 0, 1, 0, 0, 1, 3));
        tv.push_back(vec(0, 0, 0, z, 0, 0, 1, 0, 0, 0, 0));
        // age order: W makes p9 busy, X waits on p9, Y and Z ready
        tv.push_back(vec(0, 0, 1, mk(10, 1, 9, 0, 0, 0, 0), 0, 0, 1, 1, 0, 0, 0));
        tv.push_back(vec(0, 0, 1, mk(4, 0, 0, 1, 9, 0, 0), 0, 0, 1, 1, 0, 1, 10));
        tv.push_back(vec(0, 0, 1, mk(5, 0, 0, 0, 0, 0, 0), 0, 0, 1, 2, 0, 0, 0));
        tv.push_back(vec(0, 0, 1, mk(6, 0, 0, 0, 0, 0, 0), 0, 0, 1, 2, 0, 1, 5));
        tv.push_back(vec(0, 0, 0, z, 0, 0, 1, 1, 0, 1, 6));
        tv.push_back(vec(0, 0, 0, z, 1, 9, 1, 1, 0, 0, 0));
        tv.push_back(vec(0, 0, 0, z, 0, 0, 1, 0, 0, 1, 4));
        tv.push_back(vec(0, 0, 0, z, 0, 0, 1, 0, 0, 0, 0));
        // same-cycle bypass and clear-wins on p12
        tv.push_back(vec(0, 0, 1, mk(11, 1, 12, 0, 0, 0, 0), 0, 0, 1, 1, 0, 0, 0));
        tv.push_back(vec(0, 0, 1, mk(7, 0, 0, 0, 0, 1, 12), 1, 12, 1, 1, 0, 1, 11));
        tv.push_back(vec(0, 0, 1, mk(8, 1, 12, 0, 0, 0, 0), 1, 12, 1, 1, 0, 1, 7));
        tv.push_back(vec(0, 0, 1, mk(9, 0, 0, 1, 12, 0, 0), 0, 0, 1, 1, 0, 1, 8));
        tv.push_back(vec(0, 0, 0, z, 0, 0, 1, 1, 0, 0, 0));
        tv.push_back(vec(0, 0, 0, z, 1, 12, 1, 1, 0, 0, 0));
        tv.push_back(vec(0, 0, 0, z, 0, 0, 1, 0, 0, 1, 9));
        tv.push_back(vec(0, 0, 0, z, 0, 0, 1, 0, 0, 0, 0));

        for (int i = 0; i < tv.size(); i++) begin
            drive(tv[i].rst, tv[i].flush, tv[i].v, tv[i].u, tv[i].wv, tv[i].wt, tv[i].ir);
            expect_state($sformatf("vec%0d", i), tv[i].e_cnt, tv[i].e_full, tv[i].e_ov, tv[i].e_op);
        end

        // backpressure: fill output register plus 7 queued entries
        for (int k = 0; k < 8; k++) begin
            drive(0, 0, 1, mk(20 + k, 0, 0, 0, 0, 0, 0), 0, 0, 0);
        end
        expect_state("bp_fill", 7, 0, 1, 20);
        drive(0, 0, 1, mk(28, 0, 0, 0, 0, 0, 0), 0, 0, 0);
        expect_state("bp_ninth", 8, 1, 1, 20);
        drive(0, 0, 1, mk(29, 0, 0, 0, 0, 0, 0), 0, 0, 0);
        expect_state("bp_tenth", 8, 1, 1, 20);
        for (int k = 1; k <= 8; k++) begin
            drive(0, 0, 0, z, 0, 0, 1);
            expect_state($sformatf("bp_drain%0d", k), 8 - k, 0, 1, 20 + k);
        end
        drive(0, 0, 0, z, 0, 0, 1);
        expect_state("bp_empty", 0, 0, 0, 0);

        // flush mid-operation with busy tags p30/p31
        drive(0, 0, 1, mk(40, 1, 30, 0, 0, 0, 0), 0, 0, 0);
        expect_state("fl_a", 1, 0, 0, 0);
        drive(0, 0, 1, mk(41, 1, 31, 1, 30, 0, 0), 0, 0, 0);
        expect_state("fl_b", 1, 0, 1, 40);
        drive(0, 0, 1, mk(42, 0, 0, 1, 31, 0, 0), 0, 0, 0);
        drive(0, 0, 1, mk(43, 0, 0, 0, 0, 0, 0), 0, 0, 0);
        drive(0, 0, 1, mk(44, 0, 0, 0, 0, 0, 0), 0, 0, 0);
        expect_state("fl_pre", 4, 0, 1, 40);
        drive(0, 1, 1, mk(45, 0, 0, 0, 0, 0, 0), 1, 30, 0);
        expect_state("fl_post", 0, 0, 0, 0);
        drive(0, 0, 1, mk(46, 0, 0, 1, 30, 1, 31), 0, 0, 1);
        expect_state("fl_redisp", 1, 0, 0, 0);
        drive(0, 0, 0, z, 0, 0, 1);
        expect_state("fl_issue", 0, 0, 1, 46);

        // reset overrides a dispatch
        drive(1, 0, 1, mk(47, 0, 0, 0, 0, 0, 0), 0, 0, 1);
        expect_state("rst_prio", 0, 0, 0, 0);
        chk("rst_out_zero", int'(uop_out), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
